nibble_serial_adder: RTL and testbench

//   Multi-cycle WIDTH-bit adder/subtractor feeding one 4-bit ripple-carry slice (four_bit_RCA_RCS),
//   one nibble per cycle, LSB nibble first, with the carry held in a register between cycles.

---
 rtl/nibble_serial_adder.sv | 190 +++++++++++++++++++
 tb/tb_nibble_serial_adder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//   Multi-cycle WIDTH-bit adder/subtractor built around one 4-bit ripple-carry
//   slice. Operands are accepted in IDLE. One nibble is processed per clock,
//   LSB nibble first, with the carry held in a register between nibbles. The
//   result is held in DONE until the consumer takes it. Only one operation is
//   in flight at a time.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands present
//   in_ready   out  block can accept operands (IDLE only, never while in reset)
//   a, b       in   WIDTH-bit operands (two's complement for ovf)
//   cin        in   carry-in for addition; ignored when op_sub=1
//   op_sub     in   0: a+b+cin, 1: a-b computed as a+~b+1
//   out_valid  out  result present
//   out_ready  in   consumer accepts result
//   sum        out  WIDTH-bit result, meaningful only while out_valid=1
//   cout       out  carry out of the MSB (subtract: 1 = no borrow)
//   ovf        out  signed overflow
// -----------------------------------------------------------------------------
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / 4;
  // A single-nibble build still needs a one-bit counter.
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // 4-bit ripple-carry slice: returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] rca4(input logic [3:0] x, input logic [3:0] y,
                                      input logic c);
    logic [4:0] r;
    logic       cc;
    cc = c;
    r  = 5'd0;
    for (int i = 0; i < 4; i++) begin
      r[i] = x[i] ^ y[i] ^ cc;
      cc   = (x[i] & y[i]) | (cc & (x[i] ^ y[i]));
    end
    r[4] = cc;
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;       // b already inverted for subtraction
  logic            carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            rdy_en_q;        // keeps in_ready low until first edge after reset

  logic            accept_s;
  logic            last_s;
  logic [WIDTH-1:0] a_sh_s, b_sh_s, nib_sh_s;
  logic [4:0]      slice_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) state_d = ST_RUN;
        else          state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s) state_d = ST_DONE;
        else        state_d = ST_RUN;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
        else           state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from registered state.
  always_comb begin
    in_ready  = (state_q == ST_IDLE) && rdy_en_q;
    out_valid = (state_q == ST_DONE);
    sum       = sum_q;
    cout      = cout_q;
    ovf       = ovf_q;
  end

  // Slice operand selection for the current nibble.
  always_comb begin
    accept_s = in_valid && (state_q == ST_IDLE) && rdy_en_q;
    last_s   = (cnt_q == CW'(NIBBLES - 1));
    a_sh_s   = a_q >> {cnt_q, 2'b00};
    b_sh_s   = b_q >> {cnt_q, 2'b00};
    nib_sh_s = WIDTH'(4'hF) << {cnt_q, 2'b00};
    slice_s  = rca4(a_sh_s[3:0], b_sh_s[3:0], carry_q);
  end

  // Datapath next-state: operand capture in IDLE, one nibble per RUN cycle.
  always_comb begin
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          a_d     = a;
          b_d     = op_sub ? ~b : b;
          carry_d = op_sub ? 1'b1 : cin;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q;
        end
      end
      ST_RUN: begin
        sum_d   = (sum_q & ~nib_sh_s) | (WIDTH'(slice_s[3:0]) << {cnt_q, 2'b00});
        carry_d = slice_s[4];
        if (last_s) begin
          cnt_d  = '0;
          cout_d = slice_s[4];
          // Overflow: operands agree in sign but the result sign differs.
          ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[3] != a_q[WIDTH-1]);
        end else begin
          cnt_d  = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      rdy_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // WIDTH=16 instance
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [15:0] a = 16'h0, b = 16'h0, sum;
  logic        cin = 1'b0, op_sub = 1'b0, cout, ovf;

  // WIDTH=4 instance
  logic        w4_in_valid = 1'b0, w4_in_ready, w4_out_valid, w4_out_ready = 1'b0;
  logic [3:0]  w4_a = 4'h0, w4_b = 4'h0, w4_sum;
  logic        w4_cin = 1'b0, w4_op_sub = 1'b0, w4_cout, w4_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op_sub(op_sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(w4_in_valid), .in_ready(w4_in_ready),
    .a(w4_a), .b(w4_b), .cin(w4_cin), .op_sub(w4_op_sub), .out_valid(w4_out_valid),
    .out_ready(w4_out_ready), .sum(w4_sum), .cout(w4_cout), .ovf(w4_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for in_ready, sampling on the falling edge.
  task automatic wait_ready(input string tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  // Full operation with latency, result and handshake checks.
  task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic cv, input logic sv,
                       input logic [15:0] es, input logic ec, input logic eo);
    wait_ready(tag);
    a = av; b = bv; cin = cv; op_sub = sv; in_valid = 1'b1;
    @(posedge clk); #1;               // accept edge E0
    in_valid = 1'b0;
    chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      chk({tag, "_early"}, {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;               // E0+4
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_sum"},   {16'd0, sum},       {16'd0, es});
    chk({tag, "_cout"},  {31'd0, cout},      {31'd0, ec});
    chk({tag, "_ovf"},   {31'd0, ovf},       {31'd0, eo});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_idle"},  {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum",       {16'd0, sum},       32'd0);
    chk("rst_cout_ovf",  {30'd0, cout, ovf}, 32'd0);
    #10 rst_n = 1'b1;                 // release at t=12, before edge at 15
    #1;
    chk("rel_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rel_in_ready_high", {31'd0, in_ready}, 32'd1);

    // Directed arithmetic vectors
    do_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    do_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("add_cin",   16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
    do_op("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_ovf",   16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Backpressure in DONE with an in_valid pulse that must be ignored
    wait_ready("hold");
    a = 16'h1111; b = 16'h2222; cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // ovf/cout keep previous op's value (1/1) until the last nibble
    chk("hold_prev_ovf",  {31'd0, ovf},  32'd1);
    chk("hold_prev_cout", {31'd0, cout}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("hold_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      a = 16'hAAAA; b = 16'h5555; in_valid = (i == 2);
      @(posedge clk); #1;
      chk("hold_sum",      {16'd0, sum},       32'h3333);
      chk("hold_flags",    {30'd0, cout, ovf}, 32'd0);
      chk("hold_in_ready", {31'd0, in_ready},  32'd0);
      chk("hold_valid_kept", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hold_released", {31'd0, out_valid}, 32'd0);
    chk("hold_sum_after", {16'd0, sum}, 32'h3333);

    // Reset in the 2nd RUN cycle
    wait_ready("mid_rst");
    a = 16'h1234; b = 16'h4321; cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;               // first nibble written
    chk("mid_rst_nib0", {28'd0, sum[3:0]}, 32'h5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_sum",   {16'd0, sum},       32'd0);
    chk("mid_rst_ready", {31'd0, in_ready},  32'd0);
    chk("mid_rst_flags", {30'd0, cout, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

    // WIDTH=4: single RUN cycle
    @(negedge clk);
    chk("w4_ready", {31'd0, w4_in_ready}, 32'd1);
    w4_a = 4'h9; w4_b = 4'h9; w4_cin = 1'b1; w4_op_sub = 1'b0; w4_in_valid = 1'b1;
    @(posedge clk); #1;
    w4_in_valid = 1'b0;
    chk("w4_early", {31'd0, w4_out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("w4_valid", {31'd0, w4_out_valid}, 32'd1);
    chk("w4_sum",   {28'd0, w4_sum},       32'h3);
    chk("w4_cout",  {31'd0, w4_cout},      32'd1);
    chk("w4_ovf",   {31'd0, w4_ovf},       32'd1);
    w4_out_ready = 1'b1;
    @(posedge clk); #1;
    w4_out_ready = 1'b0;
    chk("w4_drain", {31'd0, w4_out_valid}, 32'd0);
    chk("w4_idle",  {31'd0, w4_in_ready},  32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
